// File: rtl/regfile_pkg.sv
// Shared constants and types for the architectural register file.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_adr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register. An issue marks its
// destination busy and a write-back clears it. When both hit the same register
// in the same cycle, the issue wins.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   issue_valid_i, issue_adr_i mark a destination busy
//   wb_en_i, wb_adr_i          write-back clears the busy bit
//   rs1_adr_i, rs2_adr_i       source addresses being requested
//   src1_blocked, src2_blocked source still waiting on a write-back (combinational)
module regfile_scoreboard #(
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_adr_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [ADDR_W-1:0] rs1_adr_i,
  input  logic [ADDR_W-1:0] rs2_adr_i,
  output logic              src1_blocked,
  output logic              src2_blocked
);
  import regfile_pkg::ZERO_REG;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first, then set, so a same-cycle issue leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i && (wb_adr_i != ADDR_W'(ZERO_REG))) begin
      busy_d[wb_adr_i] = 1'b0;
    end
    if (issue_valid_i && (issue_adr_i != ADDR_W'(ZERO_REG))) begin
      busy_d[issue_adr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Uses the pre-edge busy bit. A write-back landing this cycle unblocks because it is bypassed.
  assign src1_blocked = busy_q[rs1_adr_i] & ~(wb_en_i & (wb_adr_i == rs1_adr_i));
  assign src2_blocked = busy_q[rs2_adr_i] & ~(wb_en_i & (wb_adr_i == rs2_adr_i));

endmodule

// File: rtl/register_file.sv
// Architectural register file: 32 x 32-bit registers, with x0 hardwired to zero.
// It has two registered read ports with write-back bypass, one write-back port,
// and a pending-write scoreboard that stalls reads of busy sources.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   rd_req, rs1_adr/rs2_adr operand read request and source addresses
//   rs1_data/rs2_data       registered operands
//   rd_ack                  registered; operands updated by last cycle's accepted read
//   stall                   combinational; read blocked by a busy source
//   issue_valid, issue_adr  mark destination pending
//   wb_en, wb_adr, wb_data  write-back port
module register_file #(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rs1_adr,
  input  logic [ADDR_W-1:0] rs2_adr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rd_ack,
  output logic              stall,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_adr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [DATA_W-1:0] wb_data
);
  import regfile_pkg::ZERO_REG;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic              rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0] rs1_fwd, rs2_fwd;
  logic              src1_blocked, src2_blocked;
  logic              accept;

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid_i(issue_valid),
    .issue_adr_i  (issue_adr),
    .wb_en_i      (wb_en),
    .wb_adr_i     (wb_adr),
    .rs1_adr_i    (rs1_adr),
    .rs2_adr_i    (rs2_adr),
    .src1_blocked (src1_blocked),
    .src2_blocked (src2_blocked)
  );

  assign stall  = rd_req & (src1_blocked | src2_blocked);
  assign accept = rd_req & ~stall;

  // Storage; x0 is never written, so it reads as zero from reset onward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en && (wb_adr != ADDR_W'(ZERO_REG))) begin
      regs_q[wb_adr] <= wb_data;
    end
  end

  // Operand bypass: a same-cycle write-back beats storage, and x0 beats both.
  always_comb begin
    rs1_fwd = regs_q[rs1_adr];
    rs2_fwd = regs_q[rs2_adr];
    if (wb_en && (wb_adr == rs1_adr)) rs1_fwd = wb_data;
    if (wb_en && (wb_adr == rs2_adr)) rs2_fwd = wb_data;
    if (rs1_adr == ADDR_W'(ZERO_REG)) rs1_fwd = '0;
    if (rs2_adr == ADDR_W'(ZERO_REG)) rs2_fwd = '0;
  end

  // Output registers load only on an accepted read and hold otherwise.
  always_comb begin
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rd_ack_d   = accept;
    if (accept) begin
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_ack_q   <= 1'b0;
    end else begin
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rd_ack_q   <= rd_ack_d;
    end
  end

  assign rs1_data = rs1_data_q;
  assign rs2_data = rs2_data_q;
  assign rd_ack   = rd_ack_q;

endmodule

// File: doc/register_file.md
# register_file

Architectural register file feeding the operand-select stage: 32 × 32-bit registers, two synchronous read ports, one write-back port, and a pending-write scoreboard. It produces the registered operand words that the downstream read multiplexer and execute stage consume, and raises a stall when a requested source still awaits a write-back. Register 0 is hardwired to zero.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register address width
- `NUM_REGS`, 32, number of registers (= 2**ADDR_W)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rd_req`  in  1  operand read request this cycle
- `rs1_adr`  in  ADDR_W  source 1 address
- `rs2_adr`  in  ADDR_W  source 2 address
- `rs1_data`  out  DATA_W  registered source 1 operand
- `rs2_data`  out  DATA_W  registered source 2 operand
- `rd_ack`  out  1  registered; operands updated by the previous cycle's accepted request
- `stall`  out  1  combinational; request blocked by a busy source
- `issue_valid`  in  1  a write to `issue_adr` is now pending
- `issue_adr`  in  ADDR_W  destination being marked busy
- `wb_en`  in  1  write-back strobe
- `wb_adr`  in  ADDR_W  write-back address
- `wb_data`  in  DATA_W  write-back data

## Operation
- Storage `regs[NUM_REGS]` and scoreboard `busy[NUM_REGS]`.
- Write: `wb_en` with `wb_adr != 0` → `regs[wb_adr] <= wb_data`, `busy[wb_adr] <= 0`. A write to address 0 is ignored.
- Issue: `issue_valid` with `issue_adr != 0` → `busy[issue_adr] <= 1`. Address 0 is never busy.
- Issue and write-back to the same address in the same cycle: the set wins, so `busy` stays 1.
- Source blocked: `busy[rsX_adr] & ~(wb_en & wb_adr == rsX_adr)`. Blocking uses the pre-edge `busy`; a same-cycle write-back unblocks.
- `stall = rd_req & (blocked(rs1) | blocked(rs2))`.
- Accepted read: `rd_req & ~stall`.
  - `rsX_data <=` bypass value: `wb_data` if `wb_en & wb_adr == rsX_adr & rsX_adr != 0`; else `regs[rsX_adr]`.
  - Address 0 always reads 0.
- Not accepted: `rs1_data` and `rs2_data` hold their values.
- A same-cycle issue to a source being read does not block that read; the old value is read.

## Timing
- Reset values (async assert, sync release): all `regs` 0, all `busy` 0, `rs1_data`/`rs2_data` 0, `rd_ack` 0.
- Reset mid-operation discards pending writes and clears the scoreboard.
- Read latency is 1 cycle: request accepted at edge N gives data and `rd_ack = 1` after edge N. `rd_ack = 0` the cycle after a stall or an idle cycle.
- `stall` has no registered delay; the requester must hold `rd_req` and the addresses until `stall = 0`.
- Write-to-read visibility is 0 cycles via bypass.
- Back-to-back accepted reads give `rd_ack` high every cycle.

## Structure
- Package `regfile_pkg`:
  - constants `DATA_W`, `ADDR_W`, `NUM_REGS`, `ZERO_REG = 0`
  - typedefs `reg_adr_t` (logic [ADDR_W-1:0]) and `word_t` (logic [DATA_W-1:0])
- Sub-module `regfile_scoreboard`:
  - holds the `busy` vector with set/clear priority
  - outputs `src1_blocked` and `src2_blocked` with the write-back unblock applied
- The top level holds storage, bypass muxes, output registers and `rd_ack`.

## Test plan
- Reset, then read x3/x4 → `rs1_data = rs2_data = 0`, `rd_ack = 1` one cycle later. Write x0 = 0xDEADBEEF, then read x0 → 0.
- Write x5 = 0x1234_5678 and read x5 in the same cycle → `rs1_data = 0x1234_5678` next cycle (bypass).
- Issue x7, then `rd_req` on x7 → `stall = 1` and data holds for 3 cycles. Write-back x7 = 0xA5A5_0001 → `stall = 0` that cycle, and `rs2_data = 0xA5A5_0001`, `rd_ack = 1` next cycle.
- Issue x9 and write-back x9 = 0x11 in the same cycle → x9 still busy; a following read stalls until a second write-back.
- With x2 busy, x3 ready and `rd_req`: rs1 = x3, rs2 = x2 → stall. Assert `rst_n = 0` mid-stall → all outputs 0 and busy cleared; after release the read of x2 returns 0 with no stall.
